// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// flush and Tnew aging. Optional perf counters under `PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int TNEW_W = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_regwrite,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_regwrite,
    output logic [REG_W-1:0]  out_wreg,
    output logic [TNEW_W-1:0] out_tnew
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic                main_rw_q, main_rw_d, skid_rw_q, skid_rw_d;
    logic [REG_W-1:0]    main_wreg_q, main_wreg_d, skid_wreg_q, skid_wreg_d;
    logic [TNEW_W-1:0]   main_tnew_q, main_tnew_d, skid_tnew_q, skid_tnew_d;
    logic                accept, consume, main_valid;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // SKID=1 reports a registered ready; SKID=0 may pass out_ready straight through
    assign main_valid = (state_q != ST_EMPTY);
    assign in_ready   = (SKID != 0) ? (state_q != ST_SKID)
                                    : ((state_q == ST_EMPTY) || out_ready);
    assign accept     = in_valid && in_ready;
    assign consume    = main_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_rw_d   = main_rw_q;
        main_wreg_d = main_wreg_q;
        main_tnew_d = sat_dec(main_tnew_q);
        skid_data_d = skid_data_q;
        skid_rw_d   = skid_rw_q;
        skid_wreg_d = skid_wreg_q;
        skid_tnew_d = sat_dec(skid_tnew_q);
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d = in_data;
                    main_rw_d   = in_regwrite;
                    main_wreg_d = in_wreg;
                    main_tnew_d = sat_dec(in_tnew);
                    state_d     = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept && (consume || SKID == 0)) begin
                    main_data_d = in_data;
                    main_rw_d   = in_regwrite;
                    main_wreg_d = in_wreg;
                    main_tnew_d = sat_dec(in_tnew);
                end else if (accept) begin
                    skid_data_d = in_data;
                    skid_rw_d   = in_regwrite;
                    skid_wreg_d = in_wreg;
                    skid_tnew_d = sat_dec(in_tnew);
                    state_d     = ST_SKID;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // skid is always the younger entry, so it becomes the new head
                if (consume) begin
                    main_data_d = skid_data_q;
                    main_rw_d   = skid_rw_q;
                    main_wreg_d = skid_wreg_q;
                    main_tnew_d = sat_dec(skid_tnew_q);
                    state_d     = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        main_rw_q   <= main_rw_d;
        main_wreg_q <= main_wreg_d;
        main_tnew_q <= main_tnew_d;
        skid_data_q <= skid_data_d;
        skid_rw_q   <= skid_rw_d;
        skid_wreg_q <= skid_wreg_d;
        skid_tnew_q <= skid_tnew_d;
    end

    // Payload fields read as zero whenever the head is empty
    assign out_valid    = main_valid;
    assign out_data     = main_valid ? main_data_q : '0;
    assign out_wreg     = main_valid ? main_wreg_q : '0;
    assign out_tnew     = main_valid ? main_tnew_q : '0;
    assign out_regwrite = main_valid && main_rw_q && (main_wreg_q != '0);

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_valid && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
        if (!main_valid) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (SKID=1): directed steps plus random traffic against
// a queue-based model of the stage (capacity 2, Tnew aging on held entries).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_regwrite;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_wreg, out_wreg;
    logic [1:0]  in_tnew, out_tnew;
    logic        out_valid, out_ready, out_regwrite;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
    int unsigned m_stall, m_bubble;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .REG_W(5), .TNEW_W(2), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_regwrite(in_regwrite), .in_wreg(in_wreg), .in_tnew(in_tnew),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_regwrite(out_regwrite), .out_wreg(out_wreg), .out_tnew(out_tnew)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic        rw;
        logic [4:0]  wr;
        int          tn;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance model with the inputs currently applied, clock once, compare.
    task automatic step();
        bit   acc, cons;
        ent_t e;
        acc  = in_valid && (q.size() < 2);
        cons = (q.size() > 0) && out_ready;
`ifdef PIPE_STAGE_PERF_EN
        if (reset) begin
            m_stall = 0; m_bubble = 0;
        end else begin
            if (q.size() > 0 && !out_ready) m_stall++;
            if (q.size() == 0) m_bubble++;
        end
`endif
        if (reset) begin
            q.delete();
            acc = 1'b0;
        end else begin
            if (cons) void'(q.pop_front());
            foreach (q[i]) if (q[i].tn > 0) q[i].tn--;
            if (flush) q.delete();
            else if (acc) begin
                e.d = in_data; e.rw = in_regwrite; e.wr = in_wreg;
                e.tn = (in_tnew == 0) ? 0 : int'(in_tnew) - 1;
                q.push_back(e);
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_data", out_data, (q.size() > 0) ? q[0].d : 32'h0);
        chk("out_wreg", out_wreg, (q.size() > 0) ? q[0].wr : 5'h0);
        chk("out_tnew", out_tnew, (q.size() > 0) ? q[0].tn : 0);
        chk("out_regwrite", out_regwrite, (q.size() > 0) && q[0].rw && (q[0].wr != 0));
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
    endtask

    task automatic offer(input logic [31:0] d, input logic [1:0] t);
        in_valid = 1'b1; in_data = d; in_tnew = t;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 32'hDEAD; in_regwrite = 1'b1; in_wreg = 5'd3; in_tnew = 2'd2;
        // Reset held two cycles with in_valid high
        step(); step();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 32'h0);
        reset = 1'b0; in_valid = 1'b0;
        step();
        chk("post_reset_in_ready", in_ready, 1'b1);

        // Pass-through stream
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'h10 + i, 2'd2);
            step();
            chk("pass_data", out_data, 32'h10 + i);
            chk("pass_tnew", out_tnew, 2'd1);
        end
        in_valid = 1'b0;
        step();

        // Stall into skid, then drain
        out_ready = 1'b0;
        offer(32'hA, 2'd2); step();
        chk("stall_A_tnew1", out_tnew, 2'd1);
        offer(32'hB, 2'd3); step();
        chk("skid_in_ready", in_ready, 1'b0);
        chk("stall_A_tnew0", out_tnew, 2'd0);
        step();
        in_valid = 1'b0; step();
        chk("stall_A_hold", out_data, 32'hA);
        out_ready = 1'b1; step();
        chk("drain_B_data", out_data, 32'hB);
        chk("drain_B_tnew", out_tnew, 2'd0);
        step();
        chk("drain_empty", out_valid, 1'b0);

        // Flush with both entries held and a concurrent offer
        out_ready = 1'b0;
        offer(32'hC1, 2'd1); step();
        offer(32'hC2, 2'd1); step();
        offer(32'hF0, 2'd2); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1; step();
        chk("flush_dropped", out_valid, 1'b0);

        // $0 write suppression
        offer(32'h55, 2'd0); in_regwrite = 1'b1; in_wreg = 5'd0; step();
        chk("wreg0_regwrite", out_regwrite, 1'b0);
        in_wreg = 5'd5; step();
        chk("wreg5_regwrite", out_regwrite, 1'b1);
        in_valid = 1'b0; step();

`ifdef PIPE_STAGE_PERF_EN
        // Three stall cycles then two empty cycles
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b0; offer(32'h77, 2'd0); step();
        in_valid = 1'b0; step(); step(); step();
        out_ready = 1'b1; step(); step(); step();
        chk("perf_stall", stall_cnt, 32'd3);
`endif

        // Random traffic; a refused offer is held stable until accepted
        last_acc = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                in_data     = $urandom;
                in_regwrite = $urandom_range(0, 1);
                in_wreg     = $urandom_range(0, 31);
                in_tnew     = $urandom_range(0, 3);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core; generalises the fixed E->M register.
- Carries an opaque payload plus the hazard-unit fields (RegWrite, write register, Tnew) between any two stages.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, flush, and Tnew aging while an entry is held.
- Instantiated once per stage boundary (D/E, E/M, M/W) with different widths.

Parameters:
- DATA_W, 32: payload width in bits (PC, instr, ALUOut, WriteData, control bits concatenated by the instantiating stage).
- REG_W, 5: register-number width.
- TNEW_W, 2: Tnew field width.
- SKID, 1: 1 = two entries (main + skid), registered in_ready; 0 = single entry, combinational in_ready.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard every held entry
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage accepts this cycle
- in_data  in  DATA_W  payload
- in_regwrite  in  1  entry writes the GPR file
- in_wreg  in  REG_W  destination register
- in_tnew  in  TNEW_W  cycles until the result exists, as seen by the upstream stage
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes the head entry
- out_data  out  DATA_W  head payload
- out_regwrite  out  1  out_valid & head regwrite & (head wreg != 0)
- out_wreg  out  REG_W  head destination register
- out_tnew  out  TNEW_W  head Tnew, aged

Behaviour:
- Reset and values:
  - Reset is synchronous, active-high, on clk; it overrides flush and every transfer.
  - On reset: all entries invalid, out_valid=0, out_data=0, out_wreg=0, out_tnew=0, out_regwrite=0.
  - in_ready is 1 in the first cycle after reset.
  - When out_valid=0, out_data, out_wreg and out_tnew are 0.
- Transfers:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - Latency is 1 cycle: an entry accepted into an empty stage appears on the outputs the next cycle.
- Tnew on entry: stored tnew = (in_tnew==0) ? 0 : in_tnew-1.
- Tnew aging:
  - Every cycle an entry stays held (main or skid), its tnew decrements, saturating at 0.
  - Hazard logic therefore never sees a stale Tnew during a stall.
- SKID=1 state machine (registered in_ready = ~skid_valid):
  - EMPTY: accept -> FULL.
  - FULL:
    - accept & consume: main <= input; stay FULL.
    - accept & ~consume: skid <= input -> SKID.
    - consume & ~accept -> EMPTY.
  - SKID: in_ready=0.
    - consume: main <= skid (aged); skid cleared -> FULL.
  - Order is preserved: the skid entry is always younger than the main entry.
- SKID=0:
  - in_ready = ~out_valid | out_ready, combinational.
  - Accept loads main; consume without accept empties it.
  - A combinational path from out_ready to in_ready is permitted in this mode only.
- Flush:
  - Next state is EMPTY and all valids are cleared.
  - An entry accepted in the flush cycle is dropped; in_ready is still reported.
  - Consume in the flush cycle still counts as consumed.
- Write-register zero: out_regwrite is forced to 0 when out_wreg==0 (never forward/write $0).
- No overflow: accept never happens in SKID state. Upstream holding in_valid while in_ready=0 is legal, and its data must be held stable.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined, two extra outputs are present:
  - stall_cnt[31:0]: increments each cycle with out_valid & ~out_ready.
  - bubble_cnt[31:0]: increments each cycle with ~out_valid.
  - Both counters clear on reset, are not affected by flush, and wrap from 0xFFFFFFFF to 0.
- Without the macro: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1 the cycle after reset drops.
- Pass-through: out_ready=1, stream 4 entries with data 0x10..0x13 and in_tnew=2 -> each appears 1 cycle later in order, out_tnew=1.
- Stall with SKID=1:
  - out_ready=0; push A (tnew=2), then B (tnew=3) -> state SKID, in_ready=0; out_tnew for A shows 1, then 0, then stays 0.
  - Raise out_ready -> A, then B emitted in order; B's tnew has aged to 0.
- Flush: FULL+SKID held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, accepted entry not emitted.
- $0 suppression: in_regwrite=1, in_wreg=0 -> out_regwrite=0; in_wreg=5 -> out_regwrite=1.
- PERF (macro defined): 3 stall cycles then 2 empty cycles -> stall_cnt=3, bubble_cnt=2 (plus reset-idle cycles counted).
